// File: rtl/mem2_wb_pkg.sv
// Shared encodings for the mem2/write-back stage: access widths, stage states, exception bits.
package mem2_wb_pkg;

   localparam int DATA_W = 32;
   localparam int EXP_W  = 7;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_FULL  = 2'b01;
   localparam logic [1:0] ST_EXC   = 2'b10;

   localparam int EXP_ALE = 4;

   // Half needs addr[0]=0; word (10 or 11) needs addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr);
      logic bad;
      bad = 1'b0;
      if (width == W_HALF)
         bad = addr[0];
      else if (width[1])
         bad = (addr != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/mem2_wb_load_align.sv
// Combinational load aligner: shifts the raw cache word to the addressed lane and extends it.
module load_align
   import mem2_wb_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        addr,
   input  logic [1:0]        width,
   input  logic              sign,
   output logic [DATA_W-1:0] result
);

   logic [DATA_W-1:0] byte_lane;
   logic [DATA_W-1:0] half_lane;
   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   assign byte_lane = data >> {addr, 3'b000};
   assign half_lane = data >> {addr[1], 4'b0000};
   assign byte_s    = byte_lane[7:0];
   assign half_s    = half_lane[15:0];

   always_comb begin
      result = data;
      case (width)
         W_BYTE: result = sign ? DATA_W'(byte_s) : {24'd0, byte_lane[7:0]};
         W_HALF: result = sign ? DATA_W'(half_s) : {16'd0, half_lane[15:0]};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/mem2_wb.sv
// mem2 -> write-back stage: registers aligned load data, single-shot write strobe, exception hold.
// Optional MEM2_ALIGN_CHECK_EN raises EXP_ALE on misaligned half/word accesses.
module mem2_wb
   import mem2_wb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_en,
   input  logic [4:0]        in_rd,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_addr,
   input  logic [1:0]        in_width,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [DATA_W-1:0] in_badv,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [EXP_W-1:0]  wb_exp,
   output logic [DATA_W-1:0] wb_badv,
   output logic              fwd_valid
);

   logic [1:0]        state_p1;
   logic              written_p1;
   logic [4:0]        rd_p1;
   logic [DATA_W-1:0] data_p1;
   logic [EXP_W-1:0]  exp_p1;
   logic [DATA_W-1:0] badv_p1;

   logic              cap;
   logic [DATA_W-1:0] aligned_p0;
   logic [EXP_W-1:0]  exp_p0;
   logic [DATA_W-1:0] badv_p0;
   logic [1:0]        state_nxt;

   load_align u_align (
      .data   (in_data),
      .addr   (in_addr[1:0]),
      .width  (in_width),
      .sign   (in_sign),
      .result (aligned_p0)
   );

`ifdef MEM2_ALIGN_CHECK_EN
   logic ale_p0;
   assign ale_p0  = is_misaligned(in_width, in_addr[1:0]);
   assign exp_p0  = in_exp | (EXP_W'(ale_p0) << EXP_ALE);
   assign badv_p0 = ale_p0 ? in_addr : in_badv;
`else
   assign exp_p0  = in_exp;
   assign badv_p0 = in_badv;
`endif

   // An instruction parked in EXC blocks any new capture until flushed.
   assign cap = in_en & ~stall & ~flush & (state_p1 != ST_EXC);

   always_comb begin
      state_nxt = state_p1;
      if (flush)
         state_nxt = ST_EMPTY;
      else if (!stall) begin
         case (state_p1)
            ST_EMPTY, ST_FULL:
               if (cap)
                  state_nxt = (exp_p0 != '0) ? ST_EXC : ST_FULL;
               else
                  state_nxt = ST_EMPTY;
            default: state_nxt = ST_EXC;
         endcase
      end
   end

   // p0 -> p1: capture boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p1   <= ST_EMPTY;
         written_p1 <= 1'b0;
         rd_p1      <= '0;
         data_p1    <= '0;
         exp_p1     <= '0;
         badv_p1    <= '0;
      end else begin
         state_p1 <= state_nxt;
         // Written flips after the first FULL cycle even while stalled, so a held load strobes once.
         if (cap)
            written_p1 <= 1'b0;
         else if (state_p1 == ST_FULL)
            written_p1 <= 1'b1;
         if (cap) begin
            rd_p1   <= in_rd;
            data_p1 <= aligned_p0;
            exp_p1  <= exp_p0;
            badv_p1 <= badv_p0;
         end
      end
   end

   assign wb_rd     = rd_p1;
   assign wb_data   = data_p1;
   assign wb_exp    = exp_p1;
   assign wb_badv   = badv_p1;
   assign wb_en     = (state_p1 == ST_FULL) & (rd_p1 != 5'd0) & ~written_p1;
   assign fwd_valid = (state_p1 == ST_FULL) & (rd_p1 != 5'd0) & (exp_p1 == '0);

endmodule

// File: tb/tb_mem2_wb.sv
// Directed bench for mem2_wb: alignment, single-shot strobe, stall/flush, EXC hold and async reset.
module tb_mem2_wb;

   logic        clk = 1'b0;
   logic        rst, flush, stall, in_en, in_sign;
   logic [4:0]  in_rd;
   logic [31:0] in_data, in_addr, in_badv;
   logic [1:0]  in_width;
   logic [6:0]  in_exp;
   logic        wb_en, fwd_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, wb_badv;
   logic [6:0]  wb_exp;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem2_wb dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall), .in_en(in_en),
      .in_rd(in_rd), .in_data(in_data), .in_addr(in_addr), .in_width(in_width),
      .in_sign(in_sign), .in_exp(in_exp), .in_badv(in_badv),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exp(wb_exp),
      .wb_badv(wb_badv), .fwd_valid(fwd_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] addr,
                       input logic [1:0] width, input logic sign);
      in_en = 1'b1; in_rd = rd; in_data = data; in_addr = addr; in_width = width; in_sign = sign;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0; in_en = 1'b0; in_sign = 1'b0;
      in_rd = '0; in_data = '0; in_addr = '0; in_badv = '0; in_width = '0; in_exp = '0;
      tick(); tick();
      check("rst_en", wb_en, 0);
      check("rst_rd", wb_rd, 0);
      check("rst_data", wb_data, 0);
      check("rst_exp", wb_exp, 0);
      check("rst_badv", wb_badv, 0);
      check("rst_fwd", fwd_valid, 0);
      rst = 1'b0;

      // signed byte, lane 3
      load(5'd3, 32'h80AABBCC, 32'h1003, 2'b00, 1'b1);
      tick();
      check("sb_data", wb_data, 32'hFFFFFF80);
      check("sb_en", wb_en, 1);
      check("sb_rd", wb_rd, 3);
      check("sb_fwd", fwd_valid, 1);
      in_en = 1'b0;
      tick();
      check("sb_en_drop", wb_en, 0);
      check("sb_fwd_drop", fwd_valid, 0);

      // unsigned half upper, then back-to-back captures
      load(5'd5, 32'hF00D1234, 32'h2002, 2'b01, 1'b0);
      tick();
      check("uh_data", wb_data, 32'h0000F00D);
      check("uh_rd", wb_rd, 5);
      check("uh_en", wb_en, 1);
      load(5'd6, 32'h12345678, 32'h2001, 2'b00, 1'b0);
      tick();
      check("ub_data", wb_data, 32'h00000056);
      check("ub_en_b2b", wb_en, 1);
      load(5'd7, 32'h12348001, 32'h0010, 2'b01, 1'b1);
      tick();
      check("sh_data", wb_data, 32'hFFFF8001);
      check("sh_rd", wb_rd, 7);

      // word then 3 stall cycles: one strobe, data held
      load(5'd9, 32'hDEADBEEF, 32'h0040, 2'b10, 1'b0);
      tick();
      check("w_en", wb_en, 1);
      check("w_data", wb_data, 32'hDEADBEEF);
      stall = 1'b1;
      load(5'd10, 32'h01010101, 32'h0044, 2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_en", wb_en, 0);
         check("stall_data", wb_data, 32'hDEADBEEF);
         check("stall_rd", wb_rd, 9);
         check("stall_fwd", fwd_valid, 1);
      end
      stall = 1'b0; in_en = 1'b0;
      tick();
      check("unstall_fwd", fwd_valid, 0);
      check("unstall_en", wb_en, 0);

      // store (rd=0) passes without strobe
      load(5'd0, 32'hAAAA5555, 32'h0080, 2'b10, 1'b0);
      tick();
      check("st_en", wb_en, 0);
      check("st_fwd", fwd_valid, 0);
      check("st_data", wb_data, 32'hAAAA5555);

      // upstream exception: EXC holds, ignores in_en, leaves on flush
      load(5'd4, 32'h11111111, 32'h0090, 2'b10, 1'b0);
      in_exp = 7'h05; in_badv = 32'h0000BAD0;
      tick();
      check("exc_en", wb_en, 0);
      check("exc_exp", wb_exp, 7'h05);
      check("exc_badv", wb_badv, 32'h0000BAD0);
      check("exc_fwd", fwd_valid, 0);
      in_exp = '0; in_badv = '0;
      load(5'd12, 32'h22222222, 32'h00A0, 2'b10, 1'b0);
      tick();
      check("exc_hold_exp", wb_exp, 7'h05);
      check("exc_hold_data", wb_data, 32'h11111111);
      check("exc_hold_en", wb_en, 0);
      flush = 1'b1;
      tick();
      check("exc_flush_en", wb_en, 0);
      flush = 1'b0;
      load(5'd2, 32'h00000011, 32'h00B0, 2'b10, 1'b0);
      tick();
      check("post_flush_en", wb_en, 1);
      check("post_flush_data", wb_data, 32'h00000011);

`ifdef MEM2_ALIGN_CHECK_EN
      // misaligned word raises ALE and reports the address
      load(5'd8, 32'hCAFEF00D, 32'h3001, 2'b10, 1'b0);
      in_badv = 32'h00007777;
      tick();
      check("ale_en", wb_en, 0);
      check("ale_exp", wb_exp, 7'h10);
      check("ale_badv", wb_badv, 32'h00003001);
      check("ale_fwd", fwd_valid, 0);
      in_badv = '0;
      load(5'd9, 32'h33333333, 32'h0000, 2'b10, 1'b0);
      tick();
      check("ale_hold_exp", wb_exp, 7'h10);
      check("ale_hold_en", wb_en, 0);
      flush = 1'b1; in_en = 1'b0;
      tick();
      flush = 1'b0;
      load(5'd9, 32'h33333333, 32'h0000, 2'b10, 1'b0);
      tick();
      check("ale_after_flush_en", wb_en, 1);
`else
      // misaligned accesses take the shift only; badv passes through
      load(5'd8, 32'hCAFEF00D, 32'h3001, 2'b10, 1'b0);
      in_badv = 32'h00007777;
      tick();
      check("mis_w_en", wb_en, 1);
      check("mis_w_data", wb_data, 32'hCAFEF00D);
      check("mis_w_exp", wb_exp, 0);
      check("mis_w_badv", wb_badv, 32'h00007777);
      in_badv = '0;
      load(5'd9, 32'hAAAA1234, 32'h3001, 2'b01, 1'b0);
      tick();
      check("mis_h_data", wb_data, 32'h00001234);
      check("mis_h_en", wb_en, 1);
`endif

      // flush beats stall while FULL
      stall = 1'b1; flush = 1'b1; in_en = 1'b1;
      tick();
      check("flush_stall_fwd", fwd_valid, 0);
      check("flush_stall_en", wb_en, 0);
      stall = 1'b0;

      // flush and in_en together: no capture
      load(5'd13, 32'h44444444, 32'h00C0, 2'b10, 1'b0);
      tick();
      check("flush_cap_en", wb_en, 0);
      check("flush_cap_fwd", fwd_valid, 0);
      flush = 1'b0;

      // async reset mid-FULL clears outputs immediately
      load(5'd3, 32'h00000055, 32'h00D0, 2'b10, 1'b0);
      tick();
      check("pre_rst_en", wb_en, 1);
      in_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_en", wb_en, 0);
      check("arst_rd", wb_rd, 0);
      check("arst_data", wb_data, 0);
      check("arst_fwd", fwd_valid, 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_en", wb_en, 0);
      check("post_rst_fwd", fwd_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
